// File: rtl/cla_pipe_if.sv
// Handshake and operand/result bundle for cla_pipe.
// out_ovf exists only when CLA_PIPE_OVF_EN is defined.
interface cla_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
`ifdef CLA_PIPE_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum
    );
`endif
endinterface

// File: rtl/cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor behind valid/ready.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    cla_pipe_if.slave  bus
);
    // Handshake: a beat moves on either side when valid & ready are both high
    // at a rising edge; a stage loads when it is empty or its consumer advances.
    localparam int NG  = WIDTH / 4;
    localparam int NSB = (NG + 3) / 4;
    localparam int NGP = NSB * 4;

    // Carries c1..c4 of a 4-wide lookahead block.
    function automatic logic [3:0] look4(input logic [3:0] g, input logic [3:0] p,
                                         input logic c0);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Carries c0..c3 feeding the bits of one 4-bit group.
    function automatic logic [3:0] grp4(input logic [3:0] g, input logic [3:0] p,
                                        input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_d, p_q, g_d, g_q;
    logic [NG-1:0]    gg_d, gg_q, gp_d, gp_q;
    logic             cin_d, cin_q, s1_valid_d, s1_valid_q;
    logic [NGP-1:0]   gg_pad, gp_pad;
    logic [NGP:0]     gc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   out_sum_d, out_sum_q;
    logic             out_valid_d, out_valid_q;
`ifdef CLA_PIPE_OVF_EN
    logic             a_msb_d, a_msb_q, b_msb_d, b_msb_q, out_ovf_d, out_ovf_q;
`endif

    always_comb begin
        s2_adv = !out_valid_q | bus.out_ready;
        s1_adv = !s1_valid_q | s2_adv;
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;

    // Stage 1: bit generate/propagate and group-level gout/pout.
    always_comb begin
        b_eff      = bus.in_sub ? ~bus.in_b : bus.in_b;
        p_d        = p_q;
        g_d        = g_q;
        gg_d       = gg_q;
        gp_d       = gp_q;
        cin_d      = cin_q;
        s1_valid_d = s1_valid_q;
`ifdef CLA_PIPE_OVF_EN
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
`endif
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                g_d   = bus.in_a & b_eff;
                p_d   = bus.in_a ^ b_eff;
                cin_d = bus.in_sub;
                for (int k = 0; k < NG; k++) begin
                    gg_d[k] = g_d[4*k+3] | (p_d[4*k+3] & g_d[4*k+2])
                            | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                            | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
                    gp_d[k] = &p_d[4*k +: 4];
                end
`ifdef CLA_PIPE_OVF_EN
                a_msb_d = bus.in_a[WIDTH-1];
                b_msb_d = b_eff[WIDTH-1];
`endif
            end
        end
    end

    // Stage 2: group carries per 4-group super-block, rippling between blocks.
    always_comb begin
        gg_pad         = '0;
        gp_pad         = '0;
        gg_pad[NG-1:0] = gg_q;
        gp_pad[NG-1:0] = gp_q;
        gc             = '0;
        gc[0]          = cin_q;
        for (int sb = 0; sb < NSB; sb++) begin
            gc[4*sb+1 +: 4] = look4(gg_pad[4*sb +: 4], gp_pad[4*sb +: 4], gc[4*sb]);
        end
        sum = '0;
        for (int k = 0; k < NG; k++) begin
            sum[4*k +: 4] = p_q[4*k +: 4] ^ grp4(g_q[4*k +: 4], p_q[4*k +: 4], gc[k]);
        end

        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
`ifdef CLA_PIPE_OVF_EN
        out_ovf_d   = out_ovf_q;
`endif
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sum_d = {gc[NG], sum};
`ifdef CLA_PIPE_OVF_EN
                out_ovf_d = (a_msb_q == b_msb_q) & (sum[WIDTH-1] != a_msb_q);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            g_q         <= '0;
            gg_q        <= '0;
            gp_q        <= '0;
            cin_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            g_q         <= g_d;
            gg_q        <= gg_d;
            gp_q        <= gp_d;
            cin_q       <= cin_d;
            s1_valid_q  <= s1_valid_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef CLA_PIPE_OVF_EN
    assign bus.out_ovf = out_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            out_ovf_q <= out_ovf_d;
        end
    end
`endif
endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: WIDTH=8/32/64 instances run in lockstep on shared handshake
// controls, checked against an arithmetic reference model and an in-order queue.
module tb_cla_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, sub;
    logic [63:0] a, b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cla_pipe_if #(.WIDTH(8))  if8 ();
    cla_pipe_if #(.WIDTH(32)) if32 ();
    cla_pipe_if #(.WIDTH(64)) if64 ();

    assign if8.in_valid   = in_valid;
    assign if8.in_a       = a[7:0];
    assign if8.in_b       = b[7:0];
    assign if8.in_sub     = sub;
    assign if8.out_ready  = out_ready;
    assign if32.in_valid  = in_valid;
    assign if32.in_a      = a[31:0];
    assign if32.in_b      = b[31:0];
    assign if32.in_sub    = sub;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_a      = a;
    assign if64.in_b      = b;
    assign if64.in_sub    = sub;
    assign if64.out_ready = out_ready;

    cla_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    cla_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    cla_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    typedef struct packed {
        logic [64:0] s8;
        logic [64:0] s32;
        logic [64:0] s64;
        logic [2:0]  ovf;
    } exp_t;

    exp_t exp_q[$];

    // Reference: plain modular / signed arithmetic on wide integers.
    function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                  input logic msub, input int w,
                                  output logic [64:0] s, output logic ovf);
        logic [127:0]        m, aa, bb, r;
        logic signed [127:0] sa, sb, rs, lim;
        m   = (128'd1 << w) - 128'd1;
        aa  = {64'd0, ma} & m;
        bb  = {64'd0, mb} & m;
        r   = msub ? aa + (128'd1 << w) - bb : aa + bb;
        s   = r[64:0];
        sa  = aa[w-1] ? $signed(aa) - $signed(128'd1 << w) : $signed(aa);
        sb  = bb[w-1] ? $signed(bb) - $signed(128'd1 << w) : $signed(bb);
        rs  = msub ? sa - sb : sa + sb;
        lim = $signed(128'd1 << (w - 1));
        ovf = (rs >= lim) || (rs < -lim);
    endfunction

    function automatic exp_t expect_beat(input logic [63:0] ea, input logic [63:0] eb,
                                         input logic esub);
        exp_t e;
        model(ea, eb, esub, 8,  e.s8,  e.ovf[0]);
        model(ea, eb, esub, 32, e.s32, e.ovf[1]);
        model(ea, eb, esub, 64, e.s64, e.ovf[2]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes away from the edge, score output, log input.
    task automatic cycle(output logic acc);
        exp_t e;
        #1;
        acc = in_valid && if32.in_ready;
        if (if32.out_valid && out_ready) begin
            chk("out_expected", 65'(exp_q.size() > 0), 65'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sum8",  65'(if8.out_sum),  e.s8);
                chk("sum32", 65'(if32.out_sum), e.s32);
                chk("sum64", 65'(if64.out_sum), e.s64);
`ifdef CLA_PIPE_OVF_EN
                chk("ovf8",  65'(if8.out_ovf),  65'(e.ovf[0]));
                chk("ovf32", 65'(if32.out_ovf), 65'(e.ovf[1]));
                chk("ovf64", 65'(if64.out_ovf), 65'(e.ovf[2]));
`endif
            end
        end
        if (acc) exp_q.push_back(expect_beat(a, b, sub));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_one(input logic [63:0] da, input logic [63:0] db, input logic dsub,
                            input logic [64:0] exp32, input logic exp_ovf);
        logic acc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = da; b = db; sub = dsub;
        cycle(acc);
        chk("dir_accept", 65'(acc), 65'd1);
        in_valid = 1'b0;
        chk("dir_not_yet", 65'(if32.out_valid), 65'd0);
        cycle(acc);
        chk("dir_valid", 65'(if32.out_valid), 65'd1);
        chk("dir_sum32", 65'(if32.out_sum), exp32);
`ifdef CLA_PIPE_OVF_EN
        chk("dir_ovf32", 65'(if32.out_ovf), 65'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: undefined overflow expectation");
`endif
        cycle(acc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [63:0] bp_a [4];
        exp_t        first;
        int          i, k;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 65'(if32.in_ready), 65'd1);
        chk("rst_out_valid", 65'(if32.out_valid), 65'd0);
        chk("rst_sum32", 65'(if32.out_sum), 65'd0);
        chk("rst_sum64", 65'(if64.out_sum), 65'd0);

        send_one(64'hFFFF_FFFF, 64'h1, 1'b0, 65'h1_0000_0000, 1'b0);
        send_one(64'h5, 64'h7, 1'b1, 65'h0_FFFF_FFFE, 1'b0);
        send_one(64'h7, 64'h5, 1'b1, 65'h1_0000_0002, 1'b0);
        send_one(64'h7FFF_FFFF, 64'h1, 1'b0, 65'h0_8000_0000, 1'b1);
        send_one(64'h8000_0000, 64'h1, 1'b1, 65'h1_7FFF_FFFF, 1'b1);

        // Backpressure: only two beats fit with the consumer stalled.
        for (int j = 0; j < 4; j++) bp_a[j] = {$urandom, $urandom};
        b = 64'h0123_4567_89AB_CDEF; sub = 1'b0;
        first = expect_beat(bp_a[0], b, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1; i = 0;
        for (int j = 0; j < 6; j++) begin
            a = bp_a[i];
            cycle(acc);
            if (acc) i++;
        end
        chk("bp_accepts", 65'(i), 65'd2);
        chk("bp_in_ready", 65'(if32.in_ready), 65'd0);
        chk("bp_hold_valid", 65'(if32.out_valid), 65'd1);
        chk("bp_hold_sum", 65'(if32.out_sum), first.s32);
        out_ready = 1'b1; k = 0;
        while (i < 4 && k < 10) begin
            a = bp_a[i];
            cycle(acc);
            if (acc) i++;
            k++;
        end
        chk("bp_all_sent", 65'(i), 65'd4);
        in_valid = 1'b0; k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            cycle(acc);
            k++;
        end
        chk("bp_drained", 65'(exp_q.size()), 65'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a = {$urandom, $urandom};
            cycle(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 65'(if32.out_valid), 65'd0);
        chk("mid_rst_sum32", 65'(if32.out_sum), 65'd0);
        chk("mid_rst_in_ready", 65'(if32.in_ready), 65'd1);
`ifdef CLA_PIPE_OVF_EN
        chk("mid_rst_ovf32", 65'(if32.out_ovf), 65'd0);
`endif
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) cycle(acc);
        chk("no_stale_out", 65'(if32.out_valid), 65'd0);

        // Random traffic; the source holds a beat until it is accepted.
        acc = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a   = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
                b   = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
                sub = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1; k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            cycle(acc);
            k++;
        end
        chk("rand_drained", 65'(exp_q.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
